vx_dcr_write_sequencer: RTL and testbench
=========================================

Name: vx_dcr_write_sequencer

Overview:
- Initiator side of the DCR write bus. Drives the valid/addr/data write channel that the per-core base-DCR slaves latch.
- Out of reset it replays the boot-default base DCRs (startup address lo/hi, MPM class) autonomously.
- It then forwards host-originated DCR writes from a small FIFO, one per bus cycle, with an optional minimum inter-write gap.
- Sits in the AFU/host-interface layer, between the host command decoder and the cluster DCR broadcast.

Parameters:
- DEPTH, 4, host request FIFO entries (power of 2, >=2)
- ADDR_BITS, 12, DCR address width
- DATA_BITS, 32, DCR data width
- XLEN64, 0, 1 = also emit the STARTUP_ADDR1 write at boot
- STARTUP_ADDR, 64'h80000000, boot startup address (low 32 bits to ADDR0, high 32 bits to ADDR1)
- MPM_CLASS, 8'h00, boot MPM class (zero-extended to DATA_BITS)
- ADDR_STARTUP0, 12'h001, STARTUP_ADDR0 register address
- ADDR_STARTUP1, 12'h002, STARTUP_ADDR1 register address
- ADDR_MPM_CLASS, 12'h003, MPM_CLASS register address
- GAP, 0, idle cycles forced between consecutive bus writes

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset (0 = reset)
- req_valid  in  1  host write request valid
- req_ready  out  1  request accepted when req_valid && req_ready at clk edge
- req_addr  in  ADDR_BITS  host DCR address
- req_data  in  DATA_BITS  host DCR data
- dcr_wr_valid  out  1  registered one-cycle write strobe; the bus has no back-pressure
- dcr_wr_addr  out  ADDR_BITS  registered write address
- dcr_wr_data  out  DATA_BITS  registered write data
- init_done  out  1  boot defaults fully issued
- busy  out  1  init in progress, FIFO non-empty, or gap pending

Behaviour:
- Reset (reset==0 at edge): state=INIT0; FIFO emptied (count=0, pointers 0); gap_cnt=0; dcr_wr_valid=0, dcr_wr_addr=0, dcr_wr_data=0; init_done=0. A reset mid-operation discards queued requests and restarts the boot sequence.
- States:
  - INIT0 -> INIT1 (if XLEN64) or INIT2 -> RUN.
  - INIT0 issues {ADDR_STARTUP0, STARTUP_ADDR[31:0]}.
  - INIT1 issues {ADDR_STARTUP1, STARTUP_ADDR[63:32]}.
  - INIT2 issues {ADDR_MPM_CLASS, MPM_CLASS}.
  - Each state leaves only on the edge where it issues.
- Issue rule: a write issues at an edge when gap_cnt==0 and (state is INIT*, or state==RUN && count!=0).
  - On issue, the output registers load addr/data and dcr_wr_valid=1 for exactly one cycle; otherwise dcr_wr_valid=0 and addr/data hold their last values.
  - On issue, gap_cnt loads GAP; it decrements by 1 per cycle while nonzero.
- Boot timing: edge 0 = first edge sampling reset==1. Init writes issue at edges 0, 1+GAP, 2+2·GAP, ...
  - init_done and state RUN are registered on the edge of the last init write, so both are high the cycle that write's valid is visible.
- req_ready = (state==RUN) && (count!=DEPTH), combinational. No acceptance during INIT or when full.
  - A simultaneous pop does not free space the same cycle.
- FIFO: push on req fire; pop on RUN issue. Simultaneous push+pop leaves count unchanged. Pointers wrap modulo DEPTH.
- Latency: a request accepted at edge N (FIFO empty, gap_cnt 0) produces dcr_wr_valid during the cycle after edge N+1. Back-to-back with GAP=0, one write per cycle.
- Ordering: strict FIFO order; no address filtering or coalescing; duplicate addresses are all forwarded.
- busy = (state!=RUN) || (count!=0) || (gap_cnt!=0). busy is high during reset.

Test Plan:
- XLEN64=0, GAP=0, reset release -> valid at edges 0,1 carrying {001,80000000}, {003,00000000}; init_done=1 from edge 1; req_ready=1 after; busy=0 after edge 2.
- XLEN64=1, STARTUP_ADDR=64'h1_80000000, GAP=0 -> three writes {001,80000000}, {002,00000001}, {003,00}; init_done=1 after the 3rd.
- RUN, GAP=0, DEPTH=4: hold req_valid for 6 consecutive writes with data 0xA0..0xA5 -> all 6 appear in order at one per cycle, first 2 cycles after the first accept. Then hold dcr_wr_* stable with valid low, FIFO empty, busy=0.
- GAP=2: push 3 requests in consecutive cycles -> bus writes exactly 3 cycles apart; req_ready drops to 0 only if count reaches 4.
- req_valid asserted during INIT -> not accepted (req_ready=0), and accepted the cycle after init_done rises.
- Fill FIFO with 4 entries, assert reset for 1 cycle mid-drain -> remaining entries never appear; boot sequence replays from edge 0 of release.

Source files
------------

// File: rtl/vx_dcr_write_sequencer.sv
// -----------------------------------------------------------------------------
// vx_dcr_write_sequencer
//
// Initiator for the DCR write bus. After reset it writes the boot defaults for
// the base DCRs (startup address low, optionally startup address high, and MPM
// class). It then forwards host DCR writes from a small FIFO, at most one per
// cycle, with GAP idle cycles forced between consecutive bus writes.
//
// Ports:
//   clk           clock
//   reset         synchronous active-low reset (0 = reset)
//   req_valid     host write request valid
//   req_ready     host request accepted when req_valid && req_ready at clk edge
//   req_addr      host DCR address
//   req_data      host DCR data
//   dcr_wr_valid  registered one-cycle write strobe (bus has no back-pressure)
//   dcr_wr_addr   registered write address, holds between writes
//   dcr_wr_data   registered write data, holds between writes
//   init_done     all boot defaults have been issued
//   busy          boot in progress, FIFO non-empty, or gap pending
// -----------------------------------------------------------------------------
module vx_dcr_write_sequencer #(
  parameter int                   DEPTH          = 4,
  parameter int                   ADDR_BITS      = 12,
  parameter int                   DATA_BITS      = 32,
  parameter int                   XLEN64         = 0,
  parameter logic [63:0]          STARTUP_ADDR   = 64'h8000_0000,
  parameter logic [7:0]           MPM_CLASS      = 8'h00,
  parameter logic [ADDR_BITS-1:0] ADDR_STARTUP0  = 12'h001,
  parameter logic [ADDR_BITS-1:0] ADDR_STARTUP1  = 12'h002,
  parameter logic [ADDR_BITS-1:0] ADDR_MPM_CLASS = 12'h003,
  parameter int                   GAP            = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [ADDR_BITS-1:0] req_addr,
  input  logic [DATA_BITS-1:0] req_data,
  output logic                 dcr_wr_valid,
  output logic [ADDR_BITS-1:0] dcr_wr_addr,
  output logic [DATA_BITS-1:0] dcr_wr_data,
  output logic                 init_done,
  output logic                 busy
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int GAP_W = (GAP > 0) ? $clog2(GAP + 1) : 1;
  localparam int ENT_W = ADDR_BITS + DATA_BITS;

  typedef enum logic [1:0] {
    ST_INIT0,
    ST_INIT1,
    ST_INIT2,
    ST_RUN
  } state_e;

  state_e               state_q, state_d;
  logic [GAP_W-1:0]     gap_cnt_q, gap_cnt_d;
  logic                 init_done_q, init_done_d;
  logic                 wr_valid_q, wr_valid_d;
  logic [ADDR_BITS-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_BITS-1:0] wr_data_q, wr_data_d;

  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [ENT_W-1:0]     mem_q [DEPTH];
  logic [ENT_W-1:0]     head;

  logic                 issue;
  logic                 push;
  logic                 pop;

  // A write goes out whenever the gap has expired and there is something to
  // send: a boot default in any INIT state, or a queued host request in RUN.
  assign issue     = (gap_cnt_q == '0) && ((state_q != ST_RUN) || (count_q != '0));
  assign pop       = issue && (state_q == ST_RUN);
  // Ready looks only at the registered count, so a pop in the same cycle does
  // not make room for a push.
  assign req_ready = (state_q == ST_RUN) && (count_q != CNT_W'(DEPTH));
  assign push      = req_valid && req_ready;
  assign head      = mem_q[rd_ptr_q];

  // NOTE: every always_comb output is given a default before any branch so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d     = state_q;
    gap_cnt_d   = gap_cnt_q;
    init_done_d = init_done_q;
    wr_valid_d  = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;

    if (gap_cnt_q != '0) begin
      gap_cnt_d = gap_cnt_q - GAP_W'(1);
    end

    if (issue) begin
      wr_valid_d = 1'b1;
      gap_cnt_d  = GAP_W'(GAP);
      unique case (state_q)
        ST_INIT0: begin
          wr_addr_d = ADDR_STARTUP0;
          wr_data_d = DATA_BITS'(STARTUP_ADDR[31:0]);
          state_d   = (XLEN64 != 0) ? ST_INIT1 : ST_INIT2;
        end
        ST_INIT1: begin
          wr_addr_d = ADDR_STARTUP1;
          wr_data_d = DATA_BITS'(STARTUP_ADDR[63:32]);
          state_d   = ST_INIT2;
        end
        ST_INIT2: begin
          wr_addr_d   = ADDR_MPM_CLASS;
          wr_data_d   = DATA_BITS'(MPM_CLASS);
          state_d     = ST_RUN;
          init_done_d = 1'b1;
        end
        default: begin
          wr_addr_d = head[ENT_W-1:DATA_BITS];
          wr_data_d = head[DATA_BITS-1:0];
        end
      endcase
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_INIT0;
      gap_cnt_q   <= '0;
      init_done_q <= 1'b0;
      wr_valid_q  <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      gap_cnt_q   <= gap_cnt_d;
      init_done_q <= init_done_d;
      wr_valid_q  <= wr_valid_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  // NOTE: the FIFO storage is deliberately not reset; an entry is only read
  // after it has been written, which the reset count already guarantees.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {req_addr, req_data};
    end
  end

  assign dcr_wr_valid = wr_valid_q;
  assign dcr_wr_addr  = wr_addr_q;
  assign dcr_wr_data  = wr_data_q;
  assign init_done    = init_done_q;
  assign busy         = (state_q != ST_RUN) || (count_q != '0) || (gap_cnt_q != '0);

endmodule

// File: tb/tb_vx_dcr_write_sequencer.sv
// -----------------------------------------------------------------------------
// Bench for vx_dcr_write_sequencer. Two instances run side by side:
//   d0: defaults (32-bit boot, GAP=0)
//   d1: 64-bit boot, STARTUP_ADDR=1_80000000, MPM_CLASS=C3, GAP=2
// A transaction-level model schedules every expected bus write at the edge it
// must appear on: boot writes at k*(GAP+1), each host write at
// max(previous write + GAP + 1, accept edge + 1).
// -----------------------------------------------------------------------------
module tb_vx_dcr_write_sequencer;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [11:0] addr;
    logic [31:0] data;
    int          at;
    bit          boot;
  } wr_t;

  typedef struct packed {
    logic        rst_n;
    logic        rv;
    logic [11:0] ra;
    logic [31:0] rd;
    logic        ev;
    logic [11:0] ea;
    logic [31:0] ed;
    logic        er;
    logic        edone;
    logic        ebusy;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n_a [2];
  logic        rv_a    [2];
  logic [11:0] ra_a    [2];
  logic [31:0] rd_a    [2];
  logic        ready_w [2];
  logic        valid_w [2];
  logic [11:0] addr_w  [2];
  logic [31:0] data_w  [2];
  logic        done_w  [2];
  logic        busy_w  [2];

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  vx_dcr_write_sequencer #(
    .DEPTH(DEPTH)
  ) u_dut0 (
    .clk          (clk),
    .reset        (rst_n_a[0]),
    .req_valid    (rv_a[0]),
    .req_ready    (ready_w[0]),
    .req_addr     (ra_a[0]),
    .req_data     (rd_a[0]),
    .dcr_wr_valid (valid_w[0]),
    .dcr_wr_addr  (addr_w[0]),
    .dcr_wr_data  (data_w[0]),
    .init_done    (done_w[0]),
    .busy         (busy_w[0])
  );

  vx_dcr_write_sequencer #(
    .DEPTH       (DEPTH),
    .XLEN64      (1),
    .STARTUP_ADDR(64'h1_8000_0000),
    .MPM_CLASS   (8'hC3),
    .GAP         (2)
  ) u_dut1 (
    .clk          (clk),
    .reset        (rst_n_a[1]),
    .req_valid    (rv_a[1]),
    .req_ready    (ready_w[1]),
    .req_addr     (ra_a[1]),
    .req_data     (rd_a[1]),
    .dcr_wr_valid (valid_w[1]),
    .dcr_wr_addr  (addr_w[1]),
    .dcr_wr_data  (data_w[1]),
    .init_done    (done_w[1]),
    .busy         (busy_w[1])
  );

  // ---------------- configuration of each instance ----------------
  function automatic int gap_of(input int d);
    return (d == 0) ? 0 : 2;
  endfunction

  function automatic logic [63:0] sa_of(input int d);
    return (d == 0) ? 64'h8000_0000 : 64'h1_8000_0000;
  endfunction

  function automatic logic [31:0] mpm_of(input int d);
    return (d == 0) ? 32'h0000_0000 : 32'h0000_00C3;
  endfunction

  // ---------------- reference model state ----------------
  wr_t         q         [2][$];
  logic [43:0] obs       [2][$];
  int          obs_at    [2][$];
  int          e_m       [2];
  int          last_sch  [2];
  int          last_iss  [2];
  int          host_cnt  [2];
  int          boot_left [2];
  logic [11:0] m_addr    [2];
  logic [31:0] m_data    [2];
  bit          inited    [2];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset(input int d);
    logic [63:0] sa;
    wr_t         w;
    int          k;
    sa = sa_of(d);
    q[d].delete();
    k = 0;
    w = '{addr: 12'h001, data: sa[31:0], at: 0, boot: 1'b1};
    q[d].push_back(w);
    k++;
    if (d == 1) begin
      w = '{addr: 12'h002, data: sa[63:32], at: k * (gap_of(d) + 1), boot: 1'b1};
      q[d].push_back(w);
      k++;
    end
    w = '{addr: 12'h003, data: mpm_of(d), at: k * (gap_of(d) + 1), boot: 1'b1};
    q[d].push_back(w);
    k++;
    boot_left[d] = k;
    last_sch[d]  = (k - 1) * (gap_of(d) + 1);
    last_iss[d]  = -1000;
    host_cnt[d]  = 0;
    e_m[d]       = 0;
    m_addr[d]    = '0;
    m_data[d]    = '0;
    inited[d]    = 1'b1;
  endtask

  // Called with the next edge's inputs applied, before that edge.
  task automatic pre_edge(input int d);
    bit  exp_ready;
    int  at;
    wr_t w;
    if (inited[d]) begin
      exp_ready = (boot_left[d] == 0) && (host_cnt[d] < DEPTH);
      check($sformatf("d%0d req_ready e%0d", d, e_m[d]), 64'(ready_w[d]), 64'(exp_ready));
      if (rst_n_a[d] && rv_a[d] && exp_ready) begin
        at = last_sch[d] + gap_of(d) + 1;
        if (at < e_m[d] + 1) at = e_m[d] + 1;
        w = '{addr: ra_a[d], data: rd_a[d], at: at, boot: 1'b0};
        q[d].push_back(w);
        last_sch[d] = at;
        host_cnt[d]++;
      end
    end
  endtask

  // Called half a cycle after the edge.
  task automatic post_edge(input int d);
    bit  exp_v;
    bit  exp_busy;
    int  e;
    wr_t w;
    if (!rst_n_a[d]) begin
      model_reset(d);
      check($sformatf("d%0d rst valid", d), 64'(valid_w[d]), 64'd0);
      check($sformatf("d%0d rst addr", d), 64'(addr_w[d]), 64'd0);
      check($sformatf("d%0d rst data", d), 64'(data_w[d]), 64'd0);
      check($sformatf("d%0d rst init_done", d), 64'(done_w[d]), 64'd0);
      check($sformatf("d%0d rst busy", d), 64'(busy_w[d]), 64'd1);
    end else if (inited[d]) begin
      e = e_m[d];
      if (valid_w[d] === 1'b1) begin
        obs[d].push_back({addr_w[d], data_w[d]});
        obs_at[d].push_back(e);
      end
      exp_v = (q[d].size() > 0) && (q[d][0].at == e);
      if (exp_v) begin
        w = q[d].pop_front();
        m_addr[d]   = w.addr;
        m_data[d]   = w.data;
        last_iss[d] = e;
        if (w.boot) boot_left[d]--;
        else        host_cnt[d]--;
      end
      exp_busy = (q[d].size() != 0) || (e < last_iss[d] + gap_of(d));
      check($sformatf("d%0d valid e%0d", d, e), 64'(valid_w[d]), 64'(exp_v));
      check($sformatf("d%0d addr e%0d", d, e), 64'(addr_w[d]), 64'(m_addr[d]));
      check($sformatf("d%0d data e%0d", d, e), 64'(data_w[d]), 64'(m_data[d]));
      check($sformatf("d%0d init_done e%0d", d, e), 64'(done_w[d]), 64'(boot_left[d] == 0));
      check($sformatf("d%0d busy e%0d", d, e), 64'(busy_w[d]), 64'(exp_busy));
      e_m[d]++;
    end
  endtask

  task automatic cycle();
    for (int d = 0; d < 2; d++) pre_edge(d);
    @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) post_edge(d);
  endtask

  task automatic idle(input int n);
    for (int d = 0; d < 2; d++) rv_a[d] = 1'b0;
    for (int i = 0; i < n; i++) cycle();
  endtask

  vec_t tbl [6];

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst_n_a[d] = 1'b0;
      rv_a[d]    = 1'b0;
      ra_a[d]    = '0;
      rd_a[d]    = '0;
      inited[d]  = 1'b0;
    end

    // ---- table: d0 reset, boot, request during INIT, first host write ----
    //           rst  rv  addr     data           ev  eaddr    edata          rdy done busy
    tbl[0] = '{1'b0, 1'b0, 12'h000, 32'h0000_0000, 1'b0, 12'h000, 32'h0000_0000, 1'b0, 1'b0, 1'b1};
    tbl[1] = '{1'b1, 1'b0, 12'h000, 32'h0000_0000, 1'b1, 12'h001, 32'h8000_0000, 1'b0, 1'b0, 1'b1};
    tbl[2] = '{1'b1, 1'b1, 12'h010, 32'h0000_0011, 1'b1, 12'h003, 32'h0000_0000, 1'b1, 1'b1, 1'b0};
    tbl[3] = '{1'b1, 1'b1, 12'h010, 32'h0000_0011, 1'b0, 12'h003, 32'h0000_0000, 1'b1, 1'b1, 1'b1};
    tbl[4] = '{1'b1, 1'b0, 12'h000, 32'h0000_0000, 1'b1, 12'h010, 32'h0000_0011, 1'b1, 1'b1, 1'b0};
    tbl[5] = '{1'b1, 1'b0, 12'h000, 32'h0000_0000, 1'b0, 12'h010, 32'h0000_0011, 1'b1, 1'b1, 1'b0};

    for (int i = 0; i < 6; i++) begin
      rst_n_a[0] = tbl[i].rst_n;
      rst_n_a[1] = tbl[i].rst_n;
      rv_a[0]    = tbl[i].rv;
      ra_a[0]    = tbl[i].ra;
      rd_a[0]    = tbl[i].rd;
      rv_a[1]    = 1'b0;
      cycle();
      check($sformatf("tbl%0d valid", i), 64'(valid_w[0]), 64'(tbl[i].ev));
      check($sformatf("tbl%0d addr", i), 64'(addr_w[0]), 64'(tbl[i].ea));
      check($sformatf("tbl%0d data", i), 64'(data_w[0]), 64'(tbl[i].ed));
      check($sformatf("tbl%0d ready", i), 64'(ready_w[0]), 64'(tbl[i].er));
      check($sformatf("tbl%0d init_done", i), 64'(done_w[0]), 64'(tbl[i].edone));
      check($sformatf("tbl%0d busy", i), 64'(busy_w[0]), 64'(tbl[i].ebusy));
    end

    // ---- d1 64-bit boot: three writes, GAP+1 edges apart ----
    idle(6);
    check("d1 boot count", 64'(obs[1].size()), 64'd3);
    if (obs[1].size() == 3) begin
      check("d1 boot w0", 64'(obs[1][0]), {20'h0, 12'h001, 32'h8000_0000});
      check("d1 boot w1", 64'(obs[1][1]), {20'h0, 12'h002, 32'h0000_0001});
      check("d1 boot w2", 64'(obs[1][2]), {20'h0, 12'h003, 32'h0000_00C3});
      check("d1 boot spacing", 64'(obs_at[1][2] - obs_at[1][0]), 64'd6);
    end

    // ---- d0: six back-to-back requests A0..A5 ----
    obs[0].delete();
    obs_at[0].delete();
    for (int i = 0; i < 6; i++) begin
      rv_a[0] = 1'b1;
      ra_a[0] = 12'h100 + 12'(i);
      rd_a[0] = 32'hA0 + 32'(i);
      cycle();
    end
    idle(4);
    check("d0 burst count", 64'(obs[0].size()), 64'd6);
    if (obs[0].size() == 6) begin
      for (int i = 0; i < 6; i++) begin
        check($sformatf("d0 burst data%0d", i), 64'(obs[0][i][31:0]), 64'(32'hA0 + 32'(i)));
        if (i > 0) check($sformatf("d0 burst rate%0d", i), 64'(obs_at[0][i] - obs_at[0][i-1]), 64'd1);
      end
    end
    check("d0 idle busy", 64'(busy_w[0]), 64'd0);
    check("d0 idle hold addr", 64'(addr_w[0]), 64'h105);

    // ---- d1 GAP=2: three consecutive requests, writes 3 cycles apart ----
    obs[1].delete();
    obs_at[1].delete();
    for (int i = 0; i < 3; i++) begin
      rv_a[1] = 1'b1;
      ra_a[1] = 12'h200 + 12'(i);
      rd_a[1] = 32'hB0 + 32'(i);
      cycle();
    end
    idle(12);
    check("d1 gap count", 64'(obs[1].size()), 64'd3);
    if (obs[1].size() == 3) begin
      check("d1 gap01", 64'(obs_at[1][1] - obs_at[1][0]), 64'd3);
      check("d1 gap12", 64'(obs_at[1][2] - obs_at[1][1]), 64'd3);
    end

    // ---- d1: fill FIFO, then reset mid-drain ----
    for (int i = 0; i < 6; i++) begin
      rv_a[1] = 1'b1;
      ra_a[1] = 12'h300 + 12'(i);
      rd_a[1] = 32'hC0 + 32'(i);
      cycle();
    end
    check("d1 full ready", 64'(ready_w[1]), 64'd0);
    rv_a[1]    = 1'b0;
    rst_n_a[1] = 1'b0;
    cycle();
    rst_n_a[1] = 1'b1;
    obs[1].delete();
    obs_at[1].delete();
    idle(14);
    check("d1 post-reset writes", 64'(obs[1].size()), 64'd3);
    if (obs[1].size() == 3) begin
      check("d1 replay w0", 64'(obs[1][0]), {20'h0, 12'h001, 32'h8000_0000});
      check("d1 replay w2", 64'(obs[1][2]), {20'h0, 12'h003, 32'h0000_00C3});
    end

    // ---- randomized traffic with occasional resets ----
    for (int n = 0; n < 3000; n++) begin
      for (int d = 0; d < 2; d++) begin
        rst_n_a[d] = ($urandom_range(0, 299) != 0);
        rv_a[d]    = ($urandom_range(0, 2) != 0);
        ra_a[d]    = 12'($urandom);
        rd_a[d]    = $urandom;
      end
      cycle();
    end
    for (int d = 0; d < 2; d++) rst_n_a[d] = 1'b1;
    idle(20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
